// File: rtl/typedefs.sv
// Shared ALU types: legacy 3-bit opcode, extended 4-bit opcode, result flags.
package typedefs;

    // Opcode of the single-cycle ALU, still used by the legacy datapath.
    typedef enum logic [2:0] {
        OPC_ADD = 3'd0,
        OPC_AND = 3'd1,
        OPC_XOR = 3'd2,
        OPC_LDA = 3'd3,
        OPC_SUB = 3'd4,
        OPC_OR  = 3'd5,
        OPC_SHL = 3'd6,
        OPC_SHR = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        AND = 4'd1,
        XOR = 4'd2,
        LDA = 4'd3,
        SUB = 4'd4,
        OR  = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } alu_flags_t;

    localparam int unsigned ALU_LATENCY = 2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, data, accum) -> (result, flags).
module alu_core
    import typedefs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  alu_op_t          i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_accum,
    output logic [WIDTH-1:0] o_out,
    output alu_flags_t       o_flags
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_sum  = {1'b0, i_data} + {1'b0, i_accum};
    assign w_diff = i_accum - i_data;

    // Unknown encodings pass the accumulator through with carry/overflow clear.
    always_comb begin
        w_res   = i_accum;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_op)
            ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (i_data[MSB] == i_accum[MSB]) && (w_sum[MSB] != i_data[MSB]);
            end
            SUB: begin
                w_res   = w_diff;
                w_carry = (i_accum < i_data);
                w_ovf   = (i_accum[MSB] != i_data[MSB]) && (w_diff[MSB] != i_accum[MSB]);
            end
            AND: w_res = i_data & i_accum;
            OR:  w_res = i_data | i_accum;
            XOR: w_res = i_data ^ i_accum;
            LDA: w_res = i_data;
            SHL: {w_carry, w_res} = {i_accum, 1'b0};
            SHR: {w_res, w_carry} = {1'b0, i_accum};
            default: begin
                w_res   = i_accum;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_out            = w_res;
        o_flags.zero     = (w_res == '0);
        o_flags.carry    = w_carry;
        o_flags.overflow = w_ovf;
        o_flags.negative = w_res[MSB];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 holds result and flags.
module alu_pipe
    import typedefs::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output alu_flags_t       flags,
    output logic             acc_zero
);

    logic             r_s1_valid;
    alu_op_t          r_s1_op;
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] r_s1_accum;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    alu_flags_t       r_flags;

    logic             w_s1_ready;
    logic             w_s2_ready;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;

    // Ready ripples back combinationally so a draining S2 lets S1 advance the same cycle.
    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = w_s1_ready;

    assign acc_zero   = (accum == '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= ADD;
            r_s1_data  <= '0;
            r_s1_accum <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op    <= op;
                r_s1_data  <= data;
                r_s1_accum <= accum;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op    (r_s1_op),
        .i_data  (r_s1_data),
        .i_accum (r_s1_accum),
        .o_out   (w_res),
        .o_flags (w_flags)
    );

    // Result and flags only change when a new beat lands; they persist after transfer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_flags     <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out   <= w_res;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign flags     = r_flags;

endmodule
